// File: rtl/lm32_itlb_walker_pkg.sv
// Shared walker definitions: fault causes, FSM states, page-table index layout and PTE address helper.
package lm32_itlb_walker_pkg;

    localparam int PAGE_OFS_W = 12;

    localparam logic [1:0] LM32_WALK_CAUSE_L1  = 2'b01;
    localparam logic [1:0] LM32_WALK_CAUSE_L2  = 2'b10;
    localparam logic [1:0] LM32_WALK_CAUSE_BUS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_DONE,
        ST_FAULT
    } walk_state_e;

    // Word address of a PTE: 4 KB-aligned table base plus a 10-bit index.
    function automatic logic [31:0] pte_addr(input logic [19:0] base, input logic [9:0] idx);
        return {base, idx, 2'b00};
    endfunction

endpackage

// File: rtl/lm32_wb_read_engine.sv
// Single Wishbone read beat: cyc/stb follow req_i combinationally; done/err/data returned in the ack cycle.
// A beat with no ack/err for TIMEOUT_CYCLES cycles reports err; abort_i suppresses both results.
module lm32_wb_read_engine #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        abort_i,
    input  logic [31:0] adr_i,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] data_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       resp;
    logic       timeout;

    assign resp     = wb_ack_i | wb_err_i;
    assign timeout  = (cnt_q == TO_LAST);

    assign wb_cyc_o = req_i;
    assign wb_stb_o = req_i;
    assign wb_adr_o = req_i ? adr_i : 32'h0;
    assign data_o   = wb_dat_i;

    // An ack arriving in the last allowed cycle still completes the beat.
    assign done_o   = req_i & ~abort_i & wb_ack_i & ~wb_err_i;
    assign err_o    = req_i & ~abort_i & (wb_err_i | (~wb_ack_i & timeout));

    always_comb begin
        cnt_d = 8'h0;
        if (req_i && !resp && !abort_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= 8'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lm32_itlb_walker.sv
// Two-level ITLB page-table walker: miss -> L1 read -> L2 read -> one-cycle refill or fault strobe; abort_i cancels.
// Refill 3 cycles after accept on a zero-wait bus; define LM32_ITLB_WALKER_L1_CACHE_EN for a one-entry L1 PTE cache.
module lm32_itlb_walker
    import lm32_itlb_walker_pkg::*;
#(
    parameter int timeout_cycles = 255,
    parameter int pte_valid_bit  = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ptbr_i,
    input  logic        walk_enable_i,
    input  logic        miss_valid_i,
    input  logic [31:0] miss_vaddr_i,
    input  logic        abort_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        update_valid_o,
    output logic [31:0] update_vaddr_o,
    output logic [31:0] update_paddr_o,
    output logic        fault_o,
    output logic [31:0] fault_addr_o,
    output logic [1:0]  fault_cause_o
);

    walk_state_e state_q, state_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [19:0] l1pte_q, l1pte_d;
    logic [31:0] upd_vaddr_q, upd_vaddr_d;
    logic [31:0] upd_paddr_q, upd_paddr_d;
    logic [31:0] flt_addr_q, flt_addr_d;
    logic [1:0]  flt_cause_q, flt_cause_d;

    logic        rd_req;
    logic [31:0] rd_adr;
    logic        rd_done;
    logic        rd_err;
    logic [31:0] rd_data;
    logic        fill;
    logic        cache_hit;
    logic [19:0] cache_pte;

    lm32_wb_read_engine #(
        .TIMEOUT_CYCLES(timeout_cycles)
    ) u_rd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (rd_req),
        .abort_i  (abort_i),
        .adr_i    (rd_adr),
        .wb_adr_o (wb_adr_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .done_o   (rd_done),
        .err_o    (rd_err),
        .data_o   (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        vaddr_d     = vaddr_q;
        l1pte_d     = l1pte_q;
        upd_vaddr_d = upd_vaddr_q;
        upd_paddr_d = upd_paddr_q;
        flt_addr_d  = flt_addr_q;
        flt_cause_d = flt_cause_q;
        rd_req      = 1'b0;
        rd_adr      = 32'h0;
        fill        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!abort_i && miss_valid_i && walk_enable_i) begin
                    vaddr_d = miss_vaddr_i;
                    if (cache_hit) begin
                        l1pte_d = cache_pte;
                        state_d = ST_L2;
                    end else begin
                        state_d = ST_L1;
                    end
                end
            end
            ST_L1: begin
                rd_req = 1'b1;
                rd_adr = pte_addr(ptbr_i[31:12], vaddr_q[31:22]);
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (rd_err) begin
                    flt_addr_d  = vaddr_q;
                    flt_cause_d = LM32_WALK_CAUSE_BUS;
                    state_d     = ST_FAULT;
                end else if (rd_done) begin
                    if (rd_data[pte_valid_bit]) begin
                        l1pte_d = rd_data[31:12];
                        fill    = 1'b1;
                        state_d = ST_L2;
                    end else begin
                        flt_addr_d  = vaddr_q;
                        flt_cause_d = LM32_WALK_CAUSE_L1;
                        state_d     = ST_FAULT;
                    end
                end
            end
            ST_L2: begin
                rd_req = 1'b1;
                rd_adr = pte_addr(l1pte_q, vaddr_q[21:12]);
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (rd_err) begin
                    flt_addr_d  = vaddr_q;
                    flt_cause_d = LM32_WALK_CAUSE_BUS;
                    state_d     = ST_FAULT;
                end else if (rd_done) begin
                    if (rd_data[pte_valid_bit]) begin
                        upd_vaddr_d = {vaddr_q[31:12], {PAGE_OFS_W{1'b0}}};
                        upd_paddr_d = {rd_data[31:12], {PAGE_OFS_W{1'b0}}};
                        state_d     = ST_DONE;
                    end else begin
                        flt_addr_d  = vaddr_q;
                        flt_cause_d = LM32_WALK_CAUSE_L2;
                        state_d     = ST_FAULT;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            vaddr_q     <= 32'h0;
            l1pte_q     <= 20'h0;
            upd_vaddr_q <= 32'h0;
            upd_paddr_q <= 32'h0;
            flt_addr_q  <= 32'h0;
            flt_cause_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            vaddr_q     <= vaddr_d;
            l1pte_q     <= l1pte_d;
            upd_vaddr_q <= upd_vaddr_d;
            upd_paddr_q <= upd_paddr_d;
            flt_addr_q  <= flt_addr_d;
            flt_cause_q <= flt_cause_d;
        end
    end

`ifdef LM32_ITLB_WALKER_L1_CACHE_EN
    logic        cache_vld_q;
    logic [9:0]  cache_tag_q;
    logic [19:0] cache_pte_q;
    logic [19:0] ptbr_q;

    // A same-cycle flush or base change must not be served from the stale entry.
    assign cache_hit = cache_vld_q && !flush_i && (ptbr_i[31:12] == ptbr_q)
                       && (cache_tag_q == miss_vaddr_i[31:22]);
    assign cache_pte = cache_pte_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cache_vld_q <= 1'b0;
            cache_tag_q <= 10'h0;
            cache_pte_q <= 20'h0;
            ptbr_q      <= 20'h0;
        end else begin
            ptbr_q <= ptbr_i[31:12];
            if (flush_i) begin
                cache_vld_q <= 1'b0;
            end else if (fill) begin
                cache_vld_q <= 1'b1;
                cache_tag_q <= vaddr_q[31:22];
                cache_pte_q <= rd_data[31:12];
            end else if (ptbr_i[31:12] != ptbr_q) begin
                cache_vld_q <= 1'b0;
            end
        end
    end
`else
    logic unused_cache;

    assign cache_hit    = 1'b0;
    assign cache_pte    = 20'h0;
    assign unused_cache = flush_i ^ fill;
`endif

    logic unused_bits;
    assign unused_bits = ^{ptbr_i[11:0], rd_data[11:0]};

    assign busy_o         = (state_q != ST_IDLE);
    assign wb_we_o        = 1'b0;
    assign update_valid_o = (state_q == ST_DONE) & ~abort_i;
    assign fault_o        = (state_q == ST_FAULT) & ~abort_i;
    assign update_vaddr_o = upd_vaddr_q;
    assign update_paddr_o = upd_paddr_q;
    assign fault_addr_o   = flt_addr_q;
    assign fault_cause_o  = flt_cause_q;

endmodule

// File: tb/tb_lm32_itlb_walker.sv
// Scoreboard bench for lm32_itlb_walker: a page-table memory model answers bus beats, walks are predicted from the
// two-level translation rules, and a monitor compares every refill/fault strobe against the predicted queue.
module tb_lm32_itlb_walker;

    localparam int TO = 255;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] ptbr_i = 32'h0;
    logic        walk_enable_i = 1'b1;
    logic        miss_valid_i = 1'b0;
    logic [31:0] miss_vaddr_i = 32'h0;
    logic        abort_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        update_valid_o;
    logic [31:0] update_vaddr_o, update_paddr_o;
    logic        fault_o;
    logic [31:0] fault_addr_o;
    logic [1:0]  fault_cause_o;

    always #5 clk_i = ~clk_i;

    lm32_itlb_walker #(.timeout_cycles(TO), .pte_valid_bit(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ptbr_i(ptbr_i), .walk_enable_i(walk_enable_i),
        .miss_valid_i(miss_valid_i), .miss_vaddr_i(miss_vaddr_i), .abort_i(abort_i), .flush_i(flush_i),
        .busy_o(busy_o), .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .update_valid_o(update_valid_o), .update_vaddr_o(update_vaddr_o), .update_paddr_o(update_paddr_o),
        .fault_o(fault_o), .fault_addr_o(fault_addr_o), .fault_cause_o(fault_cause_o)
    );

    // resp: 0 = ack with memory data, 1 = err, 2 = never answer
    typedef struct { logic [31:0] adr; int wt; int resp; } beat_t;
    typedef struct { bit flt; logic [31:0] a; logic [31:0] b; logic [1:0] c; } exp_t;

    beat_t       beat_q[$];
    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          bad = 0;

    bit          mc_vld = 1'b0;
    logic [9:0]  mc_tag = 10'h0;
    logic [19:0] mc_pte = 20'h0;

    bit          sl_in_beat = 1'b0;
    beat_t       sl_cur;
    int          sl_wt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input bit flt, input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
        exp_t e;
        e.flt = flt; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic push_beat(input logic [31:0] adr, input int wt, input int resp);
        beat_t b;
        b.adr = adr; b.wt = wt; b.resp = resp;
        beat_q.push_back(b);
    endtask

    // Wishbone slave backed by the page-table memory
    initial begin
        forever begin
            @(negedge clk_i);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (!(wb_cyc_o && wb_stb_o)) begin
                sl_in_beat = 1'b0;
            end else begin
                if (!sl_in_beat) begin
                    if (beat_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_bus_beat: got adr %h want no access", wb_adr_o);
                        sl_cur.adr = wb_adr_o; sl_cur.wt = 0; sl_cur.resp = 1;
                    end else begin
                        sl_cur = beat_q.pop_front();
                        chk("bus_adr", wb_adr_o, sl_cur.adr);
                    end
                    sl_in_beat = 1'b1;
                    sl_wt = sl_cur.wt;
                end
                if (sl_wt > 0) begin
                    sl_wt--;
                end else if (sl_cur.resp == 0) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
                    sl_in_beat = 1'b0;
                end else if (sl_cur.resp == 1) begin
                    wb_err_i = 1'b1;
                    sl_in_beat = 1'b0;
                end
            end
        end
    end

    // Strobe monitor
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && (update_valid_o || fault_o)) begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_strobe: got upd=%0b flt=%0b want none", update_valid_o, fault_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {30'h0, update_valid_o, fault_o}, e.flt ? 32'h1 : 32'h2);
                    if (e.flt) begin
                        chk("fault_addr", fault_addr_o, e.a);
                        chk("fault_cause", {30'h0, fault_cause_o}, {30'h0, e.c});
                    end else begin
                        chk("upd_vaddr", update_vaddr_o, e.a);
                        chk("upd_paddr", update_paddr_o, e.b);
                    end
                end
            end
        end
    end

    task automatic set_ptbr(input logic [31:0] p);
        if (p[31:12] != ptbr_i[31:12]) mc_vld = 1'b0;
        ptbr_i = p;
        @(negedge clk_i);
    endtask

    task automatic flush_pulse();
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        mc_vld = 1'b0;
    endtask

    // mode: 0 clean, 1 err on L1, 2 err on L2, 3 no answer on L1
    task automatic do_walk(input logic [31:0] va, input logic [31:0] l1, input logic [31:0] l2,
                           input int mode_in, input int w1, input int w2);
        bit          hit;
        bit          stop;
        int          mode;
        int          lat_exp;
        int          n;
        logic [19:0] pte;
        logic [31:0] a1, a2;
        mode = mode_in;
`ifdef LM32_ITLB_WALKER_L1_CACHE_EN
        hit = mc_vld && (mc_tag == va[31:22]);
`else
        hit = 1'b0;
`endif
        if (hit && (mode == 1 || mode == 3)) mode = 0;
        lat_exp = 1;
        stop = 1'b0;
        pte = mc_pte;
        if (!hit) begin
            a1 = {ptbr_i[31:12], va[31:22], 2'b00};
            mem[a1] = l1;
            push_beat(a1, (mode == 3) ? 0 : w1, (mode == 1) ? 1 : (mode == 3) ? 2 : 0);
            if (mode == 3) begin
                lat_exp += TO;
                push_exp(1'b1, va, 32'h0, 2'b11);
                stop = 1'b1;
            end else begin
                lat_exp += w1 + 1;
                if (mode == 1) begin
                    push_exp(1'b1, va, 32'h0, 2'b11);
                    stop = 1'b1;
                end else if (!l1[0]) begin
                    push_exp(1'b1, va, 32'h0, 2'b01);
                    stop = 1'b1;
                end else begin
                    pte = l1[31:12];
                    mc_vld = 1'b1; mc_tag = va[31:22]; mc_pte = pte;
                end
            end
        end
        if (!stop) begin
            a2 = {pte, va[21:12], 2'b00};
            mem[a2] = l2;
            push_beat(a2, w2, (mode == 2) ? 1 : 0);
            lat_exp += w2 + 1;
            if (mode == 2) push_exp(1'b1, va, 32'h0, 2'b11);
            else if (!l2[0]) push_exp(1'b1, va, 32'h0, 2'b10);
            else push_exp(1'b0, {va[31:12], 12'h0}, {l2[31:12], 12'h0}, 2'b00);
        end
        miss_valid_i = 1'b1;
        miss_vaddr_i = va;
        n = 0;
        while (n < 2000) begin
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
            if (n == 1) begin
                miss_valid_i = 1'b0;
                miss_vaddr_i = $urandom;
                walk_enable_i = 1'($urandom_range(0, 1));
            end
            if (update_valid_o || fault_o) break;
        end
        chk("walk_latency", n, lat_exp);
        walk_enable_i = 1'b1;
        @(negedge clk_i);
        chk("idle_after_walk", {31'h0, busy_o}, 32'h0);
    endtask

    initial begin
        logic [31:0] va, l1, l2, a1, a2;
        int          n, r, mode;

        #2;
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_cyc_stb_we", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        chk("rst_strobes", {30'h0, update_valid_o, fault_o}, 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_upd_vaddr", update_vaddr_o, 32'h0);
        chk("rst_upd_paddr", update_paddr_o, 32'h0);
        chk("rst_fault_info", {fault_addr_o[29:0], fault_cause_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        set_ptbr(32'h00100000);

        do_walk(32'h40001234, 32'h00200001, 32'h08030001, 0, 0, 0);
        do_walk(32'h40002000, 32'h00200001, 32'h0803F001, 0, 0, 0);
        flush_pulse();
        do_walk(32'h40002000, 32'h00200001, 32'h0803F001, 0, 0, 0);
        flush_pulse();
        do_walk(32'h40001234, 32'h00200000, 32'h08030001, 0, 0, 0);
        flush_pulse();
        do_walk(32'h40001234, 32'h00200001, 32'h08030000, 0, 0, 0);
        flush_pulse();
        do_walk(32'h40001234, 32'h00200001, 32'h08030001, 1, 0, 0);
        do_walk(32'h40001234, 32'h00200001, 32'h08030001, 2, 1, 2);
        flush_pulse();
        do_walk(32'h40001234, 32'h00200001, 32'h08030001, 3, 0, 0);

        // Misses are ignored while the walker is disabled
        walk_enable_i = 1'b0;
        miss_valid_i = 1'b1;
        miss_vaddr_i = 32'h40001234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("disabled_busy", {30'h0, busy_o, wb_cyc_o}, 32'h0);
        end
        miss_valid_i = 1'b0;
        walk_enable_i = 1'b1;

        // Abort while the L2 beat is stalled
        flush_pulse();
        a1 = {ptbr_i[31:12], 10'h100, 2'b00};
        a2 = 32'h00200004;
        mem[a1] = 32'h00200001;
        mem[a2] = 32'h08030001;
        push_beat(a1, 0, 0);
        push_beat(a2, 10, 0);
        mc_vld = 1'b1; mc_tag = 10'h100; mc_pte = 20'h00200;
        miss_valid_i = 1'b1;
        miss_vaddr_i = 32'h40001234;
        n = 0;
        do begin
            @(posedge clk_i);
            @(negedge clk_i);
            n++;
            if (n == 1) miss_valid_i = 1'b0;
        end while (!(wb_cyc_o && wb_adr_o == a2) && n < 50);
        chk("abort_reach_l2", wb_adr_o, a2);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        chk("abort_busy", {31'h0, busy_o}, 32'h0);
        repeat (3) @(negedge clk_i);
        do_walk(32'h40003000, 32'h00200001, 32'h0A0B0001, 0, 0, 0);

        // Reset in the middle of a stalled L1 beat, then the cache must be cold
        a1 = {ptbr_i[31:12], 10'h200, 2'b00};
        mem[a1] = 32'h00200001;
        push_beat(a1, 20, 0);
        miss_valid_i = 1'b1;
        miss_vaddr_i = 32'h80000000;
        @(posedge clk_i);
        @(negedge clk_i);
        miss_valid_i = 1'b0;
        @(negedge clk_i);
        chk("pre_reset_cyc", {31'h0, wb_cyc_o}, 32'h1);
        rst_i = 1'b0;
        #1;
        chk("mid_reset_bus", {29'h0, wb_cyc_o, wb_stb_o, busy_o}, 32'h0);
        chk("mid_reset_strobes", {30'h0, update_valid_o, fault_o}, 32'h0);
        chk("mid_reset_adr", wb_adr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        mc_vld = 1'b0;
        @(negedge clk_i);
        do_walk(32'h40001234, 32'h00200001, 32'h08030001, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) set_ptbr(($urandom_range(0, 1) == 1) ? 32'h00100000 : 32'h00180000);
            if ($urandom_range(0, 19) == 0) flush_pulse();
            va = $urandom;
            va[31:22] = 10'h100 + 10'($urandom_range(0, 3));
            l1 = {12'h002, 8'($urandom), 11'($urandom), 1'($urandom_range(0, 5) != 0)};
            l2 = $urandom;
            l2[0] = ($urandom_range(0, 5) != 0);
            r = $urandom_range(0, 99);
            mode = (r < 6) ? 1 : (r < 12) ? 2 : (r < 14) ? 3 : 0;
            do_walk(va, l1, l2, mode, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk_i);
        chk("exp_q_drained", exp_q.size(), 32'h0);
        chk("beat_q_drained", beat_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
